// File: rtl/ysyx_22041071_rd_arbiter_pkg.sv
// Shared encodings for the IF/LS read arbiter: FSM states, grant owner,
// AXI size codes and the default AXI IDs issued per requester.
package ysyx_22041071_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_LS = 1'b1
  } grant_e;

  typedef enum logic [1:0] {
    SIZE_1B = 2'b00,
    SIZE_2B = 2'b01,
    SIZE_4B = 2'b10,
    SIZE_8B = 2'b11
  } size_e;

  localparam int         ID_W_DEF  = 4;
  localparam logic [3:0] IF_ID_DEF = 4'd0;
  localparam logic [3:0] LS_ID_DEF = 4'd1;

endpackage

// File: rtl/ysyx_22041071_rd_arbiter_sel.sv
// Two-way requester select. gnt is one-hot (bit0 = IF, bit1 = LS) or zero.
// With RR_EN=0 LS always beats IF; with RR_EN=1 a tie goes to whichever
// requester did not own the previous grant.
module ysyx_22041071_rd_arb_sel
  import ysyx_22041071_rd_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b0
) (
  input  logic       if_valid,
  input  logic       ls_valid,
  input  grant_e     last_grant,
  output logic [1:0] gnt
);

  // LS wins unless IF is also requesting and round-robin says it is IF's turn
  always_comb begin
    gnt = 2'b00;
    if (ls_valid && (!if_valid || (RR_EN == 1'b0) || (last_grant == GNT_IF)))
      gnt[1] = 1'b1;
    else if (if_valid)
      gnt[0] = 1'b1;
  end

endmodule

// File: rtl/ysyx_22041071_rd_arbiter.sv
// IF/LS read arbiter in front of the single CPU-side port of the AXI read
// master. One request is captured in IDLE, presented in ADDR until accepted,
// and its beats are routed back to the owner in DATA until the last beat.
// Build option: YSYX_22041071_RD_ARB_RR_EN selects round-robin arbitration
// (default: fixed priority, LS over IF).
module ysyx_22041071_rd_arbiter
  import ysyx_22041071_rd_arbiter_pkg::*;
#(
  parameter int              ADDR_W = 64,
  parameter int              DATA_W = 64,
  parameter int              LEN_W  = 8,
  parameter int              ID_W   = ID_W_DEF,
  parameter logic [ID_W-1:0] IF_ID  = ID_W'(IF_ID_DEF),
  parameter logic [ID_W-1:0] LS_ID  = ID_W'(LS_ID_DEF)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_ar_valid,
  input  logic [ADDR_W-1:0] if_ar_addr,
  input  logic [LEN_W-1:0]  if_ar_len,
  input  logic [1:0]        if_ar_size,
  output logic              if_ar_ready,
  output logic              if_r_valid,
  output logic [DATA_W-1:0] if_r_data,
  output logic [1:0]        if_r_resp,
  output logic              if_r_last,
  input  logic              ls_ar_valid,
  input  logic [ADDR_W-1:0] ls_ar_addr,
  input  logic [LEN_W-1:0]  ls_ar_len,
  input  logic [1:0]        ls_ar_size,
  output logic              ls_ar_ready,
  output logic              ls_r_valid,
  output logic [DATA_W-1:0] ls_r_data,
  output logic [1:0]        ls_r_resp,
  output logic              ls_r_last,
  output logic              mem_ar_valid,
  output logic [ID_W-1:0]   mem_ar_id,
  output logic [ADDR_W-1:0] mem_ar_addr,
  output logic [LEN_W-1:0]  mem_ar_len,
  output logic [1:0]        mem_ar_size,
  input  logic              mem_ar_ready,
  input  logic              mem_r_valid,
  input  logic [DATA_W-1:0] mem_r_data,
  input  logic [1:0]        mem_r_resp,
  input  logic              mem_r_last,
  output logic              len_err
);

  state_e            state, state_nxt;
  grant_e            grant;
  grant_e            last_grant;
  logic [1:0]        sel_gnt;
  logic              accept;
  logic              beat;
  logic              rd_if, rd_ls;
  logic [LEN_W-1:0]  beat_cnt;
  logic              len_err_q;
  logic [ID_W-1:0]   ar_id_q;
  logic [ADDR_W-1:0] ar_addr_q;
  logic [LEN_W-1:0]  ar_len_q;
  logic [1:0]        ar_size_q;

`ifdef YSYX_22041071_RD_ARB_RR_EN
  localparam bit RR_EN = 1'b1;

  // Remember who owned the most recent grant so a tie flips next time
  always_ff @(posedge clk) begin
    if (!reset_n)    last_grant <= GNT_IF;
    else if (accept) last_grant <= sel_gnt[1] ? GNT_LS : GNT_IF;
  end
`else
  localparam bit RR_EN = 1'b0;
  assign last_grant = GNT_IF;
`endif

  ysyx_22041071_rd_arb_sel #(.RR_EN(RR_EN)) u_sel (
    .if_valid   (if_ar_valid),
    .ls_valid   (ls_ar_valid),
    .last_grant (last_grant),
    .gnt        (sel_gnt)
  );

  assign accept = (state == ST_IDLE) && (sel_gnt != 2'b00);
  assign beat   = (state == ST_DATA) && mem_r_valid;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state: IDLE -> ADDR on capture, ADDR -> DATA on accept, DATA -> IDLE on last beat
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)                   state_nxt = ST_ADDR;
      ST_ADDR: if (mem_ar_ready)             state_nxt = ST_DATA;
      ST_DATA: if (mem_r_valid && mem_r_last) state_nxt = ST_IDLE;
      default:                               state_nxt = ST_IDLE;
    endcase
  end

  // Capture the winner's request fields, its ID and the grant owner
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      grant     <= GNT_IF;
      ar_id_q   <= '0;
      ar_addr_q <= '0;
      ar_len_q  <= '0;
      ar_size_q <= '0;
    end else if (accept) begin
      grant     <= sel_gnt[1] ? GNT_LS : GNT_IF;
      ar_id_q   <= sel_gnt[1] ? LS_ID : IF_ID;
      ar_addr_q <= sel_gnt[1] ? ls_ar_addr : if_ar_addr;
      ar_len_q  <= sel_gnt[1] ? ls_ar_len  : if_ar_len;
      ar_size_q <= sel_gnt[1] ? ls_ar_size : if_ar_size;
    end
  end

  // Beat counter: cleared at capture, wraps naturally at 2^LEN_W
  always_ff @(posedge clk) begin
    if (!reset_n)    beat_cnt <= '0;
    else if (accept) beat_cnt <= '0;
    else if (beat)   beat_cnt <= beat_cnt + LEN_W'(1);
  end

  // Sticky length error: last arrived early/late relative to the requested length
  always_ff @(posedge clk) begin
    if (!reset_n)
      len_err_q <= 1'b0;
    else if (beat && ((mem_r_last && (beat_cnt != ar_len_q)) ||
                      (!mem_r_last && (beat_cnt == ar_len_q))))
      len_err_q <= 1'b1;
  end

  assign rd_if = reset_n && beat && (grant == GNT_IF);
  assign rd_ls = reset_n && beat && (grant == GNT_LS);

  // Outputs are forced low while reset is asserted; beats go only to the owner
  always_comb begin
    if_ar_ready  = reset_n && accept && sel_gnt[0];
    ls_ar_ready  = reset_n && accept && sel_gnt[1];
    mem_ar_valid = reset_n && (state == ST_ADDR);
    mem_ar_id    = reset_n ? ar_id_q   : '0;
    mem_ar_addr  = reset_n ? ar_addr_q : '0;
    mem_ar_len   = reset_n ? ar_len_q  : '0;
    mem_ar_size  = reset_n ? ar_size_q : '0;
    len_err      = reset_n && len_err_q;
    if_r_valid   = rd_if;
    if_r_data    = rd_if ? mem_r_data : '0;
    if_r_resp    = rd_if ? mem_r_resp : 2'b00;
    if_r_last    = rd_if && mem_r_last;
    ls_r_valid   = rd_ls;
    ls_r_data    = rd_ls ? mem_r_data : '0;
    ls_r_resp    = rd_ls ? mem_r_resp : 2'b00;
    ls_r_last    = rd_ls && mem_r_last;
  end

endmodule
